// File: rtl/alu_pkg.sv
// alu_iter shared definitions: op codes and FSM states.
// Imported by the comb core and the iterative wrapper.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_iter(
    input logic [3:0] op
  );
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU core: ops 0-7, zero for everything else.
// One shared adder serves ADD, SUB and SLT.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             cmsb;
  logic             ovf;

  assign sub = (op == OP_SUB) | (op == OP_SLT);
  assign bx  = sub ? ~b : b;

  assign {cout, sum} = {1'b0, a} + {1'b0, bx}
                     + {{WIDTH{1'b0}}, sub};

  // carry into the MSB recovered from the sum bit
  assign cmsb = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];
  assign ovf  = cmsb ^ cout;

  always_comb begin
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        result   = sum;
        carryout = cout;
        overflow = ovf;
      end
      OP_SLT: begin
        result[0] = sum[WIDTH-1] ^ ovf;
      end
      OP_XOR:  result = a ^ b;
      OP_AND:  result = a & b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_OR:   result = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with valid/ready handshakes.
// MUL and shifts iterate one step per cycle in BUSY.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [3:0]         op_q;
  logic [SHW-1:0]     cnt;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   sh;

  logic [WIDTH-1:0]   c_res;
  logic               c_co;
  logic               c_ov;
  logic               accept;
  logic               go_busy;
  logic               last;
  logic [WIDTH-1:0]   start_res;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   sh_nx;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (c_res),
    .carryout(c_co),
    .overflow(c_ov)
  );

  assign in_ready = (state == IDLE)
                  | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign go_busy = (op == OP_MUL)
                 | (is_iter(op) & (b[SHW-1:0] != '0));

  // zero-length shifts finish immediately with a
  assign start_res = is_iter(op) ? a : c_res;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  assign last = (op_q == OP_MUL)
              ? (cnt == SHW'(WIDTH - 1))
              : (cnt == shamt - SHW'(1));

  always_comb begin
    sh_nx = sh;
    unique case (op_q)
      OP_SLL:  sh_nx = sh << 1;
      OP_SRL:  sh_nx = sh >> 1;
      OP_SRA:  sh_nx = {sh[WIDTH-1], sh[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt       <= '0;
      shamt     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sh        <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          cnt    <= cnt + SHW'(1);
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          sh     <= sh_nx;
          if (last) begin
            state     <= DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
            overflow  <= 1'b0;
            if (op_q == OP_MUL) begin
              result   <= acc_nx[WIDTH-1:0];
              carryout <= |acc_nx[2*WIDTH-1:WIDTH];
              zero     <= acc_nx[WIDTH-1:0] == '0;
            end else begin
              result   <= sh_nx;
              carryout <= 1'b0;
              zero     <= sh_nx == '0;
            end
          end
        end
        default: begin
          if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            op_q   <= op;
            cnt    <= '0;
            shamt  <= b[SHW-1:0];
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            sh     <= a;
            if (go_busy) begin
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= start_res;
              carryout  <= c_co;
              overflow  <= c_ov;
              zero      <= start_res == '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter, 32-bit and 8-bit instances.
// Expected results flow through a scoreboard queue.
module tb_alu_iter;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        c;
    logic        v;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        iv32, iv8;
  logic        ir32, ir8;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_ready;
  logic        ov32, ov8;
  logic [31:0] r32;
  logic [7:0]  r8;
  logic        c32, v32, z32;
  logic        c8, v8, z8;

  int n_cmp;
  int n_bad;
  exp_t sb[$];

  alu_iter #(.WIDTH(32)) u32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv32),
    .in_ready (ir32),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(ov32),
    .out_ready(out_ready),
    .result   (r32),
    .carryout (c32),
    .overflow (v32),
    .zero     (z32)
  );

  alu_iter #(.WIDTH(8)) u8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv8),
    .in_ready (ir8),
    .op       (op),
    .a        (a[7:0]),
    .b        (b[7:0]),
    .out_valid(ov8),
    .out_ready(out_ready),
    .result   (r8),
    .carryout (c8),
    .overflow (v8),
    .zero     (z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [3:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    exp_t e;
    logic [32:0] s;
    e.r = 32'd0;
    e.c = 1'b0;
    e.v = 1'b0;
    e.lat = 1;
    s = 33'd0;
    case (o)
      4'd0: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[31:0];
        e.c = s[32];
        e.v = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      4'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.r = s[31:0];
        e.c = s[32];
        e.v = (x[31] != y[31]) && (e.r[31] != x[31]);
      end
      4'd2: e.r = x ^ y;
      4'd3: e.r = {31'd0, $signed(x) < $signed(y)};
      4'd4: e.r = x & y;
      4'd5: e.r = ~(x & y);
      4'd6: e.r = ~(x | y);
      4'd7: e.r = x | y;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t t);
    exp_t e;
    e.r = t.r;
    e.c = t.c;
    e.v = t.v;
    e.z = (t.r == 32'd0);
    e.lat = t.lat;
    return e;
  endfunction

  // drive one op, wait for its result, consume it
  task automatic issue(
    input  bit          w8,
    input  logic [3:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          lat,
    output logic [31:0] r,
    output logic [2:0]  cvz,
    output bit          ok
  );
    int n;
    ok = 1'b1;
    op = o;
    a = x;
    b = y;
    if (w8) iv8 = 1'b1;
    else iv32 = 1'b1;
    n = 0;
    while (!(w8 ? ir8 : ir32) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) ok = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    iv32 = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom);
    lat = 1;
    while (!(w8 ? ov8 : ov32) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(w8 ? ov8 : ov32)) ok = 1'b0;
    r = w8 ? {24'd0, r8} : r32;
    cvz = w8 ? {c8, v8, z8} : {c32, v32, z32};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    iv32 = 1'b0;
    iv8 = 1'b0;
    out_ready = 1'b1;
    op = 4'd0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ov32, r32, c32, v32, z32, ir32} !== {1'b0, 32'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset32: got ov=%b r=%h cvz=%b%b%b rdy=%b want 0/0/000/1",
               ov32, r32, c32, v32, z32, ir32);
    end
    n_cmp++;
    if ({ov8, r8, c8, v8, z8, ir8} !== {1'b0, 8'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset8: got ov=%b r=%h rdy=%b want 0/0/1", ov8, r8, ir8);
    end
  endtask

  task automatic test_arith;
    vec_t t[6];
    exp_t e;
    int lat;
    logic [31:0] r;
    logic [2:0] cvz;
    bit ok;
    t[0] = '{4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1};
    t[1] = '{4'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
    t[2] = '{4'd3, 32'h80000000, 32'h1, 32'h1, 1'b0, 1'b0, 1};
    t[3] = '{4'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1};
    t[4] = '{4'd13, 32'h1234, 32'h5, 32'h0, 1'b0, 1'b0, 1};
    t[5] = '{4'd8, 32'h5, 32'h7, 32'd35, 1'b0, 1'b0, 33};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(from_vec(t[i]));
      issue(1'b0, t[i].o, t[i].x, t[i].y, lat, r, cvz, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat !== e.lat) begin
        n_bad++;
        $display("FAIL arith%0d latency: got %0d want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (r !== e.r || cvz !== {e.c, e.v, e.z}) begin
        n_bad++;
        $display("FAIL arith%0d: got r=%h cvz=%b want r=%h cvz=%b",
                 i, r, cvz, e.r, {e.c, e.v, e.z});
      end
    end
  endtask

  task automatic test_mul8;
    vec_t t[3];
    exp_t e;
    int lat;
    logic [31:0] r;
    logic [2:0] cvz;
    bit ok;
    t[0] = '{4'd8, 32'd15, 32'd17, 32'hFF, 1'b0, 1'b0, 9};
    t[1] = '{4'd8, 32'd16, 32'd16, 32'h0, 1'b1, 1'b0, 9};
    t[2] = '{4'd8, 32'hFF, 32'hFF, 32'h01, 1'b1, 1'b0, 9};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(from_vec(t[i]));
      issue(1'b1, t[i].o, t[i].x, t[i].y, lat, r, cvz, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat !== e.lat) begin
        n_bad++;
        $display("FAIL mul8_%0d latency: got %0d want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (r !== e.r || cvz !== {e.c, e.v, e.z}) begin
        n_bad++;
        $display("FAIL mul8_%0d: got r=%h cvz=%b want r=%h cvz=%b",
                 i, r, cvz, e.r, {e.c, e.v, e.z});
      end
    end
  endtask

  task automatic test_shift;
    vec_t t[5];
    exp_t e;
    int lat;
    logic [31:0] r;
    logic [2:0] cvz;
    bit ok;
    t[0] = '{4'd11, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 5};
    t[1] = '{4'd9, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 1};
    t[2] = '{4'd10, 32'h10, 32'd5, 32'h0, 1'b0, 1'b0, 6};
    t[3] = '{4'd9, 32'h1, 32'd31, 32'h80000000, 1'b0, 1'b0, 32};
    t[4] = '{4'd11, 32'h40000000, 32'h21, 32'h20000000, 1'b0, 1'b0, 2};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(from_vec(t[i]));
      issue(1'b0, t[i].o, t[i].x, t[i].y, lat, r, cvz, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat !== e.lat) begin
        n_bad++;
        $display("FAIL shift%0d latency: got %0d want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (r !== e.r || cvz !== {e.c, e.v, e.z}) begin
        n_bad++;
        $display("FAIL shift%0d: got r=%h cvz=%b want r=%h cvz=%b",
                 i, r, cvz, e.r, {e.c, e.v, e.z});
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic [31:0] x, y;
    x = 32'hF0F0_1234;
    y = 32'h0FF0_4321;
    out_ready = 1'b0;
    sb.push_back(model(4'd2, x, y));
    op = 4'd2;
    a = x;
    b = y;
    iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    a = 32'hDEAD_BEEF;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov32 !== 1'b1 || ir32 !== 1'b0 || r32 !== e.r
          || {c32, v32, z32} !== {e.c, e.v, e.z}) begin
        n_bad++;
        $display("FAIL hold%0d: got ov=%b rdy=%b r=%h want ov=1 rdy=0 r=%h",
                 i, ov32, ir32, r32, e.r);
      end
      @(posedge clk); #1;
    end
    x = 32'h1357_9BDF;
    y = 32'hFF00_0FF0;
    sb.push_back(model(4'd4, x, y));
    op = 4'd4;
    a = x;
    b = y;
    iv32 = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (ir32 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready: got %b want 1", ir32);
    end
    @(posedge clk); #1;
    iv32 = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (ov32 !== 1'b1 || r32 !== e.r || {c32, v32, z32} !== {e.c, e.v, e.z}) begin
      n_bad++;
      $display("FAIL bp_and: got ov=%b r=%h want ov=1 r=%h", ov32, r32, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [3:0] o;
    logic [31:0] x, y;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(0, 7));
      x = $urandom;
      y = (i == 0) ? x : $urandom;
      sb.push_back(model(o, x, y));
      op = o;
      a = x;
      b = y;
      iv32 = 1'b1;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (ov32 !== 1'b1 || r32 !== e.r || {c32, v32, z32} !== {e.c, e.v, e.z}) begin
        n_bad++;
        $display("FAIL b2b%0d op%0d: got ov=%b r=%h cvz=%b want r=%h cvz=%b",
                 i, o, ov32, r32, {c32, v32, z32}, e.r, {e.c, e.v, e.z});
      end
    end
    iv32 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    exp_t e;
    int lat;
    logic [31:0] r;
    logic [2:0] cvz;
    bit ok;
    op = 4'd8;
    a = 32'd5;
    b = 32'd7;
    iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov32 !== 1'b0 || r32 !== 32'd0) begin
      n_bad++;
      $display("FAIL async_rst: got ov=%b r=%h want 0/0", ov32, r32);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ov32, r32, c32, v32, z32, ir32} !== {1'b0, 32'd0, 4'b0001}) begin
      n_bad++;
      $display("FAIL rst_mid_mul: got ov=%b r=%h cvz=%b%b%b rdy=%b want 0/0/000/1",
               ov32, r32, c32, v32, z32, ir32);
    end
    sb.push_back(model(4'd0, 32'd1, 32'd1));
    issue(1'b0, 4'd0, 32'd1, 32'd1, lat, r, cvz, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat !== 1 || r !== e.r || r !== 32'd2) begin
      n_bad++;
      $display("FAIL add_after_rst: got r=%h lat=%0d want r=2 lat=1", r, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_arith();
    test_mul8();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
